// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, operand width and the buffered
// command record used by the issue stage.
package alu_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CMD_W = SEL_W + 2 * ALU_W + 1;

  localparam logic [SEL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [SEL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [SEL_W-1:0] ALU_AND = 3'b010;
  localparam logic [SEL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [SEL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [SEL_W-1:0] ALU_NOT = 3'b101;
  localparam logic [SEL_W-1:0] ALU_INC = 3'b110;
  localparam logic [SEL_W-1:0] ALU_DEC = 3'b111;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             chain;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// In-order command buffer with occupancy count and registered full/empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = CMD_W,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Buffers ALU commands, drives the FIFO head to the external ALU and registers
// its result behind a valid/ready output, with optional accumulator chaining.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_chain,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [CNT_W-1:0] count
);

  alu_cmd_t         in_cmd, head_cmd;
  logic [CMD_W-1:0] head_raw;
  logic             fifo_full, fifo_empty;
  logic             push, issue;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  assign in_cmd   = '{sel: in_sel, a: in_a, b: in_b, chain: in_chain};
  assign head_cmd = head_raw;

  // in_ready comes from the FIFO's registered full flag only.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign issue    = ~fifo_empty & (~out_valid_q | out_ready);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (issue),
    .wdata_i (in_cmd),
    .rdata_o (head_raw),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head drives the ALU; an empty FIFO presents all-zero operands.
  always_comb begin
    alu_sel = '0;
    alu_a   = '0;
    alu_b   = '0;
    if (!fifo_empty) begin
      alu_sel = head_cmd.sel;
      alu_a   = head_cmd.chain ? acc_q : head_cmd.a;
      alu_b   = head_cmd.b;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    acc_d       = acc_q;
    if (issue) begin
      out_valid_d = 1'b1;
      result_d    = alu_result;
      carry_d     = alu_carryout;
      zero_d      = alu_zero;
      acc_d       = alu_result;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;

endmodule
